text_line_overlay: RTL
======================

// Module: text_line_overlay
// PURPOSE
//  Parametrised VGA text overlay: draws a NUM_CHARS-glyph string at a fixed screen origin, one 8x16 font cell per char.
//  Glyph codes live in a writable char RAM; output is rgb_text plus text_on.
//  Sits between the VGA sync counter (pixel_x/pixel_y/video_on) and the colour mux.
//  Fixed 3-cycle pipeline; video_on is delayed alongside so downstream stays aligned.
// PARAMETERS
//  NUM_CHARS   8      glyphs in the line (1..64)
//  CODE_W      6      glyph code width; font ROM depth = 2**CODE_W * 16 rows
//  X0          288    left pixel column of char 0
//  Y0          232    top pixel row of the line
//  PITCH_LOG2  3      char pitch = 2**PITCH_LOG2 px (3 or 4); cols 8..pitch-1 blank
//  FG_RGB      3'b111 glyph colour;  BG_RGB 3'b000 background colour
// PORTS
//  clk         in   1      pixel clock
//  rst         in   1      async reset, active-low
//  video_on    in   1      active-video flag from sync counter
//  pixel_x     in   10     current column
//  pixel_y     in   10     current row
//  wr_en       in   1      char RAM write strobe
//  wr_addr     in   6      char index to write
//  wr_data     in   CODE_W glyph code
//  cursor_pos  in   6      cursor char index (used only with CURSOR_BLINK_EN)
//  text_on     out  1      glyph pixel lit (pipelined)
//  rgb_text    out  3      FG_RGB when text_on, else BG_RGB; 3'b000 when video_on_d low
//  video_on_d  out  1      video_on delayed 3 cycles
// BEHAVIOUR
//  Reset (rst low, async): all pipeline regs, text_on, rgb_text, video_on_d -> 0; char RAM -> code 0 (blank glyph).
//  S0 (cycle 1): dx = pixel_x - X0, dy = pixel_y - Y0 (11-bit, unsigned compare; pixel < origin = miss).
//   hit = dx < NUM_CHARS<<PITCH_LOG2 && dy < 16 && dx[PITCH_LOG2-1:0] < 8.
//   idx = dx >> PITCH_LOG2; row = dy[3:0]; col = dx[2:0].
//  S1 (cycle 2): char RAM read of idx (registered); hit,row,col,video_on delayed.
//  S2 (cycle 3): font ROM sync read at {code,row}; bit = font_word[7-col] (MSB = leftmost).
//   text_on = hit & bit & video_on delayed; rgb_text registered same edge. Latency pixel->rgb = 3 clk.
//  Write port: wr_en with wr_addr < NUM_CHARS writes wr_data; wr_addr >= NUM_CHARS ignored.
//   Same-cycle write and S1 read of same idx: read-first (old code shown); new code visible next cycle.
//  Miss pixels, blank pitch columns, video_on low: text_on = 0, never reads out-of-range RAM.
//  pixel_x/pixel_y wrap (new line/frame) needs no special handling; pipeline is stateless per pixel.
// CONFIGURATION
//  CURSOR_BLINK_EN defined:
//   frame strobe = pixel_x==0 && pixel_y==0 (one clk); 5-bit frame counter, blink phase toggles every 32 frames.
//   Phase on and idx==cursor_pos (< NUM_CHARS): cell inverted (text_on = hit & ~bit), incl. blank glyph.
//   Counter and phase reset to 0 (phase off). cursor_pos >= NUM_CHARS: no cursor.
//  Not defined: cursor_pos ignored (unconnected internally), no counter, plain rendering.
// STRUCTURE
//  Package text_overlay_pkg: GLYPH_W=8, GLYPH_H=16, CODE_W default, RGB width, blank code 0, colour constants.
//  Sub-module font_rom_8x16: sync ROM, addr {code,row}, 1-clk read latency, 8-bit row word,
//   code 0 = all zeros; instantiated once.
//  Top holds S0 arithmetic, char RAM (reg array, NUM_CHARS x CODE_W), pipeline regs, optional blink logic.
// TESTING
//  Reset: rst low mid-frame -> text_on=0, rgb_text=000, video_on_d=0 immediately; after release all chars blank.
//  Write 'I' code to idx0, sweep y=232..247, x=288..295 -> text_on matches ROM rows exactly, 3 clk after pixel.
//  Pixel x=287 or y=248 or x=288+8*NUM_CHARS -> text_on=0; PITCH_LOG2=4, x=296..303 -> 0 (gap).
//  Write idx3 in same cycle S1 reads idx3 -> old glyph that pixel, new glyph from next pixel; wr_addr=63 (NUM_CHARS=8) -> no change.
//  video_on low with lit glyph pixel -> rgb_text=000, video_on_d follows video_on by exactly 3 clk.
//  CURSOR_BLINK_EN, cursor_pos=2: frames 0..31 normal, frames 32..63 cell 2 inverted, 64 normal again.

Source files
------------

// File: rtl/text_overlay_pkg.sv
// Shared constants and types for the single-line VGA text overlay.
// Glyph codes follow ASCII minus 0x20, so code 0 is the blank (space) glyph.
package text_overlay_pkg;

   localparam int GLYPH_W    = 8;
   localparam int GLYPH_H    = 16;
   localparam int ROW_W      = 4;
   localparam int COL_W      = 3;
   localparam int CODE_W_DEF = 6;
   localparam int RGB_W      = 3;

   localparam logic [RGB_W-1:0] RGB_WHITE = 3'b111;
   localparam logic [RGB_W-1:0] RGB_BLACK = 3'b000;

   localparam int CODE_BLANK = 0;
   localparam int CODE_E     = 37;
   localparam int CODE_H     = 40;
   localparam int CODE_I     = 41;
   localparam int CODE_L     = 44;
   localparam int CODE_O     = 47;

   // Per-pixel control that rides along the pipeline beside the RAM/ROM reads.
   typedef struct packed {
      logic             hit;
      logic             inv;
      logic             von;
      logic [COL_W-1:0] col;
   } pix_ctl_t;

endpackage

// File: rtl/text_line_overlay_font_rom.sv
// 8x16 font ROM with one registered read port; address is {code, row}.
// Unlisted codes render as a hollow box so bad codes are visible on screen.
module font_rom_8x16
   import text_overlay_pkg::*;
#(
   parameter int CODE_W = CODE_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [CODE_W+ROW_W-1:0] addr,
   output logic [GLYPH_W-1:0]      row_word
);

   logic [127:0]         glyph;
   logic [GLYPH_W-1:0]   word_d;
   logic [GLYPH_W-1:0]   word_q;

   // Row 0 sits in the top byte; each row's MSB is the leftmost pixel.
   function automatic logic [127:0] glyph_bitmap(input int code);
      case (code)
         CODE_BLANK: glyph_bitmap = '0;
         CODE_E:     glyph_bitmap = 128'h0000_7E60_6060_7C60_6060_6060_7E00_0000;
         CODE_H:     glyph_bitmap = 128'h0000_6666_6666_7E7E_6666_6666_6600_0000;
         CODE_I:     glyph_bitmap = 128'h0000_7E18_1818_1818_1818_1818_7E00_0000;
         CODE_L:     glyph_bitmap = 128'h0000_6060_6060_6060_6060_6060_7E00_0000;
         CODE_O:     glyph_bitmap = 128'h0000_3C66_6666_6666_6666_6666_3C00_0000;
         default:    glyph_bitmap = 128'h0000_7E42_4242_4242_4242_4242_7E00_0000;
      endcase
   endfunction

   always_comb begin
      glyph  = glyph_bitmap(int'(addr[CODE_W+ROW_W-1:ROW_W]));
      word_d = glyph[{~addr[ROW_W-1:0], 3'b000} +: GLYPH_W];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) word_q <= '0;
      else      word_q <= word_d;
   end

   assign row_word = word_q;

endmodule

// File: rtl/text_line_overlay.sv
// Draws a NUM_CHARS glyph string at (X0,Y0) over the VGA pixel stream, 3-clock latency.
// Define CURSOR_BLINK_EN to invert the cell at cursor_pos on a 32-frame blink phase.
module text_line_overlay
   import text_overlay_pkg::*;
#(
   parameter int NUM_CHARS  = 8,
   parameter int CODE_W     = CODE_W_DEF,
   parameter int X0         = 288,
   parameter int Y0         = 232,
   parameter int PITCH_LOG2 = 3,
   parameter logic [RGB_W-1:0] FG_RGB = RGB_WHITE,
   parameter logic [RGB_W-1:0] BG_RGB = RGB_BLACK
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              video_on,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              wr_en,
   input  logic [5:0]        wr_addr,
   input  logic [CODE_W-1:0] wr_data,
   input  logic [5:0]        cursor_pos,
   output logic              text_on,
   output logic [RGB_W-1:0]  rgb_text,
   output logic              video_on_d
);

   localparam int          IDX_W       = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
   localparam logic [10:0] SPAN        = 11'(NUM_CHARS << PITCH_LOG2);
   localparam logic [10:0] GAP_MASK    = 11'(((1 << PITCH_LOG2) - 1) & ~(GLYPH_W - 1));
   localparam logic [6:0]  NUM_CHARS_7 = 7'(NUM_CHARS);

   // Pixels left of / above the origin wrap to huge values and fail the range test.
   logic [10:0] dx;
   logic [10:0] dy;
   logic        s0_inv;

   assign dx = {1'b0, pixel_x} - 11'(X0);
   assign dy = {1'b0, pixel_y} - 11'(Y0);

   pix_ctl_t          s1_ctl_d, s1_ctl_q;
   logic [IDX_W-1:0]  s1_idx_d, s1_idx_q;
   logic [ROW_W-1:0]  s1_row_d, s1_row_q;
   pix_ctl_t          s2_ctl_d, s2_ctl_q;
   logic [CODE_W-1:0] s2_code_d, s2_code_q;
   logic [ROW_W-1:0]  s2_row_d, s2_row_q;
   pix_ctl_t          s3_ctl_d, s3_ctl_q;
   logic [GLYPH_W-1:0] font_word;
   logic              pix_bit;

   logic [CODE_W-1:0] char_mem_d [NUM_CHARS];
   logic [CODE_W-1:0] char_mem_q [NUM_CHARS];

`ifdef CURSOR_BLINK_EN
   logic [4:0] frame_cnt_d, frame_cnt_q;
   logic       blink_d, blink_q;

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      blink_d     = blink_q;
      if (pixel_x == '0 && pixel_y == '0) begin
         frame_cnt_d = frame_cnt_q + 5'd1;
         if (frame_cnt_q == 5'd31) blink_d = ~blink_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         frame_cnt_q <= '0;
         blink_q     <= 1'b0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         blink_q     <= blink_d;
      end
   end

   assign s0_inv = blink_q && ({1'b0, cursor_pos} < NUM_CHARS_7)
                   && (cursor_pos == 6'(dx >> PITCH_LOG2));
`else
   logic cursor_unused;
   assign cursor_unused = ^cursor_pos;
   assign s0_inv        = 1'b0;
`endif

   always_comb begin : s0_decode
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      s1_ctl_d     = '0;
      s1_idx_d     = '0;
      s1_ctl_d.hit = (dx < SPAN) && (dy < 11'(GLYPH_H)) && ((dx & GAP_MASK) == '0);
      s1_ctl_d.inv = s0_inv;
      s1_ctl_d.von = video_on;
      s1_ctl_d.col = dx[COL_W-1:0];
      s1_row_d     = dy[ROW_W-1:0];
      // Misses keep index 0 so the RAM is never addressed past NUM_CHARS-1.
      if (s1_ctl_d.hit) s1_idx_d = IDX_W'(dx >> PITCH_LOG2);
   end

   always_comb begin : char_write
      char_mem_d = char_mem_q;
      if (wr_en && ({1'b0, wr_addr} < NUM_CHARS_7))
         char_mem_d[wr_addr[IDX_W-1:0]] = wr_data;
   end

   // Reading char_mem_q gives read-first behaviour when a write hits the same index.
   always_comb begin : s1_read
      s2_code_d = char_mem_q[s1_idx_q];
      s2_ctl_d  = s1_ctl_q;
      s2_row_d  = s1_row_q;
      s3_ctl_d  = s2_ctl_q;
   end

   // NOTE: the char RAM is reset like any register so every cell powers up as the blank glyph.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CHARS; i++) char_mem_q[i] <= '0;
      end else begin
         char_mem_q <= char_mem_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_ctl_q  <= '0;
         s1_idx_q  <= '0;
         s1_row_q  <= '0;
         s2_ctl_q  <= '0;
         s2_code_q <= '0;
         s2_row_q  <= '0;
         s3_ctl_q  <= '0;
      end else begin
         s1_ctl_q  <= s1_ctl_d;
         s1_idx_q  <= s1_idx_d;
         s1_row_q  <= s1_row_d;
         s2_ctl_q  <= s2_ctl_d;
         s2_code_q <= s2_code_d;
         s2_row_q  <= s2_row_d;
         s3_ctl_q  <= s3_ctl_d;
      end
   end

   font_rom_8x16 #(
      .CODE_W (CODE_W)
   ) u_font_rom (
      .clk      (clk),
      .rst      (rst),
      .addr     ({s2_code_q, s2_row_q}),
      .row_word (font_word)
   );

   // Outputs decode straight from stage-3 flops, so they settle with the ROM word.
   assign pix_bit    = font_word[3'(GLYPH_W - 1) - s3_ctl_q.col];
   assign text_on    = s3_ctl_q.hit & s3_ctl_q.von & (pix_bit ^ s3_ctl_q.inv);
   assign rgb_text   = !s3_ctl_q.von ? '0 : (text_on ? FG_RGB : BG_RGB);
   assign video_on_d = s3_ctl_q.von;

endmodule
